// File: rtl/pad_window_sched_pkg.sv
// rtl/pad_window_sched_pkg.sv - shared types and sizing helpers for the padding sequencer
// Purpose: scheduler state enum, padded-edge formula and counter-width helper.
//          pad_out_size() is also used by InputPad and the benches so every
//          consumer agrees on the padded map size.
package pad_win_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round size up to the next multiple of filter.
  function automatic int pad_out_size(input int size, input int filter);
    return size + ((filter - (size % filter)) % filter);
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_window_sched_if.sv
// rtl/pad_window_sched_if.sv - element stream carrying padded coordinates
// Purpose: valid/ready beat stream from the scheduler to the conv/pool unit.
// Signals: elem_valid, elem_ready, elem_row, elem_col (COORD_W each),
//          elem_pad, elem_win_last, elem_last.
// Modports: master (scheduler side), slave (consumer side).
interface pad_window_sched_if #(
  parameter int COORD_W = 4
);
  logic               elem_valid;
  logic               elem_ready;
  logic [COORD_W-1:0] elem_row;
  logic [COORD_W-1:0] elem_col;
  logic               elem_pad;
  logic               elem_win_last;
  logic               elem_last;

  modport master (
    output elem_valid, elem_row, elem_col, elem_pad, elem_win_last, elem_last,
    input  elem_ready
  );

  modport slave (
    input  elem_valid, elem_row, elem_col, elem_pad, elem_win_last, elem_last,
    output elem_ready
  );
endinterface

// File: rtl/pad_window_sched_wrap_counter.sv
// rtl/pad_window_sched_wrap_counter.sv - modulo-MAX counter with wrap strobe for chaining
// Purpose: counts 0..MAX-1 on inc, wraps to 0; wrap is high on the inc that wraps,
//          so it can drive the inc of the next counter in a chain.
// Ports: clk, reset (async, active-low), clr (sync clear, wins over inc), inc,
//        val (current count), wrap.
module wrap_counter
  import pad_win_pkg::*;
#(
  parameter  int MAX = 3,
  localparam int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val,
  output logic         wrap
);

  logic [W-1:0] val_q, val_d;

  assign wrap = inc && (val_q == W'(MAX - 1));
  assign val  = val_q;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (inc) begin
      val_d = wrap ? '0 : val_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/pad_window_sched.sv
// rtl/pad_window_sched.sv - window-ordered padded-element scheduler for the CNN pad stage
// Purpose: walks the zero-padded SIZE x SIZE map in non-overlapping
//          FILTER_SIZE x FILTER_SIZE windows (row-major windows, row-major
//          elements) and emits one coordinate beat per accepted handshake.
// Ports: clk, reset (async, active-low), en (start, sampled in IDLE),
//        busy, done (one-cycle pulse), elem (pad_window_sched_if.master),
//        win_count (only when WIN_SCHED_CNT_EN is defined).
// Option: WIN_SCHED_CNT_EN adds win_count, the number of completed windows.
module pad_window_sched
  import pad_win_pkg::*;
#(
  parameter  int SIZE        = 7,
  parameter  int FILTER_SIZE = 3,
  localparam int OUT_SIZE    = pad_out_size(SIZE, FILTER_SIZE),
  localparam int NWIN        = OUT_SIZE / FILTER_SIZE,
  localparam int COORD_W     = cnt_w(OUT_SIZE),
  localparam int CNT_W       = $clog2(NWIN * NWIN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               busy,
  output logic               done,
`ifdef WIN_SCHED_CNT_EN
  output logic [CNT_W-1:0]   win_count,
`endif
  pad_window_sched_if.master elem
);

  localparam int KW = cnt_w(FILTER_SIZE);
  localparam int WW = cnt_w(NWIN);

  state_t state_q;
  logic   busy_q, done_q, valid_q;

  logic          start, accept;
  logic [KW-1:0] kc_val, kr_val;
  logic [WW-1:0] wc_val, wr_val;
  logic          kc_wrap, kr_wrap, wc_wrap, wr_wrap;
  logic [COORD_W-1:0] row, col;
  logic          win_last;

  assign start  = (state_q == IDLE) && en;
  assign accept = valid_q && elem.elem_ready;

  // kc -> kr -> win_c -> win_r; wrap of win_r is acceptance of the final beat.
  wrap_counter #(.MAX(FILTER_SIZE)) u_kc (.clk(clk), .reset(reset), .clr(start), .inc(accept),  .val(kc_val), .wrap(kc_wrap));
  wrap_counter #(.MAX(FILTER_SIZE)) u_kr (.clk(clk), .reset(reset), .clr(start), .inc(kc_wrap), .val(kr_val), .wrap(kr_wrap));
  wrap_counter #(.MAX(NWIN))        u_wc (.clk(clk), .reset(reset), .clr(start), .inc(kr_wrap), .val(wc_val), .wrap(wc_wrap));
  wrap_counter #(.MAX(NWIN))        u_wr (.clk(clk), .reset(reset), .clr(start), .inc(wc_wrap), .val(wr_val), .wrap(wr_wrap));

  assign row      = COORD_W'(int'(wr_val) * FILTER_SIZE + int'(kr_val));
  assign col      = COORD_W'(int'(wc_val) * FILTER_SIZE + int'(kc_val));
  assign win_last = (kr_val == KW'(FILTER_SIZE - 1)) && (kc_val == KW'(FILTER_SIZE - 1));

  // Counters sit at zero outside RUN (cleared by reset or by their final wrap),
  // so the decoded coordinate outputs already read 0 there; flags are gated anyway.
  assign elem.elem_valid    = valid_q;
  assign elem.elem_row      = row;
  assign elem.elem_col      = col;
  assign elem.elem_pad      = valid_q && ((int'(row) >= SIZE) || (int'(col) >= SIZE));
  assign elem.elem_win_last = valid_q && win_last;
  assign elem.elem_last     = valid_q && win_last &&
                              (wc_val == WW'(NWIN - 1)) && (wr_val == WW'(NWIN - 1));

  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (en) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          valid_q <= 1'b1;
        end
        RUN: if (wr_wrap) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WIN_SCHED_CNT_EN
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (start) begin
      win_cnt_d = '0;
    end else if (accept && win_last) begin
      win_cnt_d = win_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_count = win_cnt_q;
`endif

endmodule

// File: tb/tb_pad_window_sched.sv
// tb/tb_pad_window_sched.sv - directed bench for pad_window_sched (SIZE 7 and 6, FILTER 3)
module tb_pad_window_sched;
  import pad_win_pkg::*;

  localparam int F  = 3;
  localparam int S7 = 7;
  localparam int S6 = 6;
  localparam int O7 = 9;
  localparam int O6 = 6;
  localparam int W7 = 4;
  localparam int W6 = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en7 = 1'b0, en6 = 1'b0;
  logic busy7, done7, busy6, done6;
`ifdef WIN_SCHED_CNT_EN
  logic [3:0] wcnt7;
  logic [2:0] wcnt6;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pad_window_sched_if #(.COORD_W(W7)) if7 ();
  pad_window_sched_if #(.COORD_W(W6)) if6 ();

  pad_window_sched #(.SIZE(S7), .FILTER_SIZE(F)) u_dut7 (
    .clk(clk), .reset(reset), .en(en7), .busy(busy7), .done(done7),
`ifdef WIN_SCHED_CNT_EN
    .win_count(wcnt7),
`endif
    .elem(if7.master)
  );

  pad_window_sched #(.SIZE(S6), .FILTER_SIZE(F)) u_dut6 (
    .clk(clk), .reset(reset), .en(en6), .busy(busy6), .done(done6),
`ifdef WIN_SCHED_CNT_EN
    .win_count(wcnt6),
`endif
    .elem(if6.master)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pk(int v, int r, int c, int p, int wl, int l);
    return (v << 19) | (r << 11) | (c << 3) | (p << 2) | (wl << 1) | l;
  endfunction

  // Independent reference: beat index -> window/element decomposition.
  function automatic int model(int i, int size, int os);
    int nw, w, e, r, c;
    nw = os / F;
    w  = i / (F * F);
    e  = i % (F * F);
    r  = (w / nw) * F + e / F;
    c  = (w % nw) * F + e % F;
    return pk(1, r, c, int'(r >= size || c >= size), int'(e == F * F - 1),
              int'(i == os * os - 1));
  endfunction

  function automatic int obs7();
    return pk(int'(if7.elem_valid), int'(if7.elem_row), int'(if7.elem_col),
              int'(if7.elem_pad), int'(if7.elem_win_last), int'(if7.elem_last));
  endfunction

  function automatic int obs6();
    return pk(int'(if6.elem_valid), int'(if6.elem_row), int'(if6.elem_col),
              int'(if6.elem_pad), int'(if6.elem_win_last), int'(if6.elem_last));
  endfunction

  initial begin
    int pads, beat, cyc, prev, cur, prev_rdy, rdy;
    if7.elem_ready = 1'b1;
    if6.elem_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_busy7", int'(busy7), 0);
    check("rst_done7", int'(done7), 0);
    check("rst_elem7", obs7(), 0);
    check("rst_elem6", obs6(), 0);
    reset = 1'b1;
    tick();

    // Full run, SIZE 7, no stalls
    en7 = 1'b1;
    tick();
    en7 = 1'b0;
    check("start_busy", int'(busy7), 1);
    pads = 0;
    for (int i = 0; i < 81; i++) begin
      cur = obs7();
      check("run7_beat", cur, model(i, S7, O7));
      pads += int'(if7.elem_pad);
      if (i == 0)  check("beat0",  cur, pk(1, 0, 0, 0, 0, 0));
      if (i == 8)  check("beat8",  cur, pk(1, 2, 2, 0, 1, 0));
      if (i == 18) check("beat18", cur, pk(1, 0, 6, 0, 0, 0));
      if (i == 19) check("beat19", cur, pk(1, 0, 7, 1, 0, 0));
      if (i == 20) check("beat20", cur, pk(1, 0, 8, 1, 0, 0));
      if (i == 80) check("beat80", cur, pk(1, 8, 8, 1, 1, 1));
      tick();
    end
    check("end_valid", int'(if7.elem_valid), 0);
    check("end_busy", int'(busy7), 0);
    check("end_done", int'(done7), 1);
`ifdef WIN_SCHED_CNT_EN
    check("win_count7", int'(wcnt7), 9);
`endif
    tick();
    check("done_drop", int'(done7), 0);
    check("pad_total7", pads, 32);

    // Random stalls: same sequence, outputs held across every stall
    en7 = 1'b1;
    tick();
    en7 = 1'b0;
    beat = 0;
    cyc = 0;
    prev = 0;
    prev_rdy = 1;
    while (beat < 81 && cyc < 2000) begin
      cur = obs7();
      check("stall_seq", cur, model(beat, S7, O7));
      if (prev_rdy == 0) check("stall_hold", cur, prev);
      prev = cur;
      rdy = int'($urandom_range(0, 1));
      if7.elem_ready = rdy[0];
      prev_rdy = rdy;
      tick();
      if (rdy == 1) beat++;
      cyc++;
    end
    check("stall_complete", beat, 81);
    check("stall_done", int'(done7), 1);
    if7.elem_ready = 1'b1;
    tick();

    // en held high: no mid-run restart, restart after one IDLE cycle
    en7 = 1'b1;
    tick();
    for (int i = 0; i < 81; i++) begin
      check("hold_seq", obs7(), model(i, S7, O7));
      tick();
    end
    check("hold_done", int'(done7), 1);
    tick();
    check("hold_idle_busy", int'(busy7), 0);
    check("hold_idle_valid", int'(if7.elem_valid), 0);
    tick();
    check("restart_busy", int'(busy7), 1);
    check("restart_beat0", obs7(), model(0, S7, O7));
    for (int i = 0; i < 40; i++) tick();
    en7 = 1'b0;
    check("beat40", obs7(), model(40, S7, O7));

    // Reset mid-run at beat 40
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy7), 0);
    check("mid_rst_done", int'(done7), 0);
    check("mid_rst_elem", obs7(), 0);
    tick();
    check("mid_rst_nodone1", int'(done7), 0);
    tick();
    check("mid_rst_nodone2", int'(done7), 0);
    reset = 1'b1;
    tick();
    check("post_rst_nodone", int'(done7), 0);
    check("post_rst_idle", obs7(), 0);
    en7 = 1'b1;
    tick();
    en7 = 1'b0;
    check("post_rst_beat0", obs7(), pk(1, 0, 0, 0, 0, 0));

    // SIZE 6: no padding, 36 beats
    en6 = 1'b1;
    tick();
    en6 = 1'b0;
    pads = 0;
    for (int i = 0; i < 36; i++) begin
      cur = obs6();
      check("run6_beat", cur, model(i, S6, O6));
      pads += int'(if6.elem_pad);
      if (i == 35) check("run6_last", cur, pk(1, 5, 5, 0, 1, 1));
      tick();
    end
    check("run6_done", int'(done6), 1);
    check("run6_valid", int'(if6.elem_valid), 0);
    check("pad_total6", pads, 0);
`ifdef WIN_SCHED_CNT_EN
    check("win_count6", int'(wcnt6), 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pad_window_sched.md
# pad_window_sched

Sequencer for the CNN input-padding stage. It walks the zero-padded input map (SIZE×SIZE rounded up to a multiple of FILTER_SIZE) in non-overlapping FILTER_SIZE×FILTER_SIZE windows. For each element it emits a padded coordinate and a pad flag over a valid/ready stream, so the downstream conv/pool unit can fetch or substitute zero. It sits between the input buffer that feeds InputPad and the filter datapath, and replaces free-running padding with a handshaked element schedule.

## Interface
- SIZE, 7, unpadded input edge length (≥1)
- FILTER_SIZE, 3, window edge length and stride (≥1)
- OUT_SIZE, derived: SIZE + ((FILTER_SIZE − SIZE%FILTER_SIZE) % FILTER_SIZE); not overridable
- COORD_W, derived: max(1, $clog2(OUT_SIZE))
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values
- en  in  1  start request, sampled only in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final beat is accepted
- elem_valid  out  1  beat available
- elem_ready  in  1  consumer accepts beat
- elem_row / elem_col  out  COORD_W each  padded-map coordinate
- elem_pad  out  1  1 when elem_row ≥ SIZE or elem_col ≥ SIZE
- elem_win_last  out  1  last beat of the current window
- elem_last  out  1  last beat of the whole map

## Operation
- FSM: IDLE → RUN when en=1. RUN → DONE on acceptance of the beat with elem_last=1. DONE → IDLE unconditionally.
- Counters: win_r, win_c ∈ [0, OUT_SIZE/FILTER_SIZE); kr, kc ∈ [0, FILTER_SIZE). All cleared on entry to RUN.
- Order: windows row-major (win_r outer); elements within a window row-major (kr outer).
- elem_row = win_r·FILTER_SIZE + kr; elem_col = win_c·FILTER_SIZE + kc. Computed at COORD_W width, no overflow possible.
- Advance only on accept (elem_valid & elem_ready): kc wraps → kr++; kr wraps → win_c++; win_c wraps → win_r++.
- elem_win_last = (kr = kc = FILTER_SIZE−1). elem_last = elem_win_last & both window counters at maximum.
- en is ignored in RUN and DONE. en held high restarts after one IDLE cycle.
- Reset mid-RUN: all state is abandoned and the FSM enters IDLE. No done pulse is generated.

## Timing
- Reset values: busy=0, done=0, elem_valid=0, elem_row=0, elem_col=0, elem_pad=0, elem_win_last=0, elem_last=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from elem_ready or en to any output.
- en=1 sampled at edge N in IDLE: busy=1 and elem_valid=1 with coordinate (0,0) from edge N+1.
- Throughput is one beat per cycle while elem_ready=1. A run takes OUT_SIZE² beats at minimum.
- While elem_valid & !elem_ready, all elem_* outputs hold stable.
- Last beat accepted at edge M: at M+1, elem_valid=0, busy=0, done=1. At M+2, done=0 (IDLE).

## Configuration
- WIN_SCHED_CNT_EN defined: adds output win_count (width $clog2((OUT_SIZE/FILTER_SIZE)²+1)), reset 0.
  - Cleared on the IDLE→RUN transition.
  - Incremented on each accepted elem_win_last beat.
  - Holds its final value after done.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package pad_win_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - function pad_out_size(size, filter) implementing the OUT_SIZE formula, also used by InputPad and the benches
- One sub-module, wrap_counter (parameter MAX, ports clk, reset, clr, inc → val, wrap), instantiated four times for kc, kr, win_c and win_r, chained via wrap.

## Test plan
- SIZE=7, FILTER_SIZE=3, elem_ready=1, pulse en: 81 beats in 81 consecutive cycles.
  - Beat 0 is (0,0) pad=0. Beat 8 is (2,2) with elem_win_last=1.
  - Beat 80 is (8,8) with pad=1 and elem_last=1. done pulses the cycle after.
- Same config, window (0,2): beats at col 6 have pad=0; cols 7 and 8 have pad=1.
  - Exactly 32 pad beats over the whole run (81 − 49).
- SIZE=6, FILTER_SIZE=3: OUT_SIZE=6, 36 beats, zero pad beats. Last beat is (5,5).
- Random elem_ready (50%): outputs stable across every stall. The sequence is identical to the no-stall run.
- en held high through busy: no restart mid-run. The second run begins one IDLE cycle after done.
- reset=0 asserted at beat 40: all outputs at reset values immediately and no done pulse. A new en restarts at (0,0).
